// File: rtl/out_display_driver.sv
// Decimal display driver: converts the output register to BCD with a sequential
// double-dabble FSM and time-multiplexes the digits onto a 7-segment display.
module out_display_driver #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 1024
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int PW   = $clog2(REFRESH_DIV);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CAPT, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  last_q, last_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [BCDW-1:0]   bcd_q, bcd_d;
  logic [BCDW-1:0]   bcdAdj;
  logic [CW-1:0]     bitcnt_q, bitcnt_d;
  logic [BCDW-1:0]   latch_q, latch_d;
  logic              valid_q, valid_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        nib;
  logic              blank;
  logic              allZero;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= '0;
      shreg_q  <= '0;
      bcd_q    <= '0;
      bitcnt_q <= '0;
      latch_q  <= '0;
      valid_q  <= 1'b0;
      presc_q  <= '0;
      idx_q    <= '0;
      seg_q    <= '0;
      an_q     <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      shreg_q  <= shreg_d;
      bcd_q    <= bcd_d;
      bitcnt_q <= bitcnt_d;
      latch_q  <= latch_d;
      valid_q  <= valid_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  // The latch only changes in DONE, so a value change mid-conversion never tears the display.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    shreg_d  = shreg_q;
    bcd_d    = bcd_q;
    bitcnt_d = bitcnt_q;
    latch_d  = latch_q;
    valid_d  = valid_q;
    bcdAdj   = bcd_q;
    case (state_q)
      IDLE: begin
        if (!valid_q || value != last_q) state_d = CAPT;
      end
      CAPT: begin
        last_d   = value;
        shreg_d  = value;
        bcd_d    = '0;
        bitcnt_d = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (bcd_q[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d    = {bcdAdj[BCDW-2:0], shreg_q[WIDTH-1]};
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q + CW'(1);
        if (bitcnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        latch_d = bcd_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Refresh scan plus digit select; blanking walks from the top digit down.
  always_comb begin
    presc_d = (presc_q == PW'(REFRESH_DIV - 1)) ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(REFRESH_DIV - 1)) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    nib     = 4'd0;
    blank   = 1'b0;
    allZero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allZero = allZero && (latch_q[4*i +: 4] == 4'd0);
      if (IW'(i) == idx_q) begin
        nib   = latch_q[4*i +: 4];
        blank = (i != 0) && allZero;
      end
    end
    seg_d = blank ? 7'h00 : decode(nib);
    an_d  = DIGITS'(1) << idx_q;
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_out_display_driver.sv
// Randomized self-checking bench for out_display_driver; expected digits are
// derived arithmetically from the displayed value.
module tb_out_display_driver;

  localparam int WIDTH       = 8;
  localparam int DIGITS      = 3;
  localparam int REFRESH_DIV = 4;

  logic              sysclk;
  logic              reset;
  logic [WIDTH-1:0]  value;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              busy;

  int testCount = 0;
  int failCount = 0;

  out_display_driver #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)
  ) dut (
    .sysclk(sysclk), .reset(reset), .value(value),
    .seg(seg), .an(an), .busy(busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: decimal digit d of v, blanked when it is a leading zero.
  function automatic logic [6:0] expSeg(input int v, input int d);
    int p = 1;
    int dig;
    for (int i = 0; i < d; i++) p = p * 10;
    dig = (v / p) % 10;
    if (d > 0 && v < p) return 7'h00;
    case (dig)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  default: return 7'h6F;
    endcase
  endfunction

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic applyStimulus(input int v);
    value = WIDTH'(v);
  endtask

  task automatic waitConversion(output int busyCycles);
    int guard = 0;
    busyCycles = 0;
    while (!busy && guard < 20) begin
      step();
      guard++;
    end
    if (!busy) begin
      checkOutput("busyStart", 0, 1);
      return;
    end
    while (busy && busyCycles < 100) begin
      busyCycles++;
      step();
    end
  endtask

  task automatic checkDisplay(input int v);
    logic [DIGITS-1:0] sel;
    int guard;
    step();
    for (int d = 0; d < DIGITS; d++) begin
      sel = '0;
      sel[d] = 1'b1;
      guard = 0;
      while (an !== sel && guard < 4 * DIGITS * REFRESH_DIV) begin
        step();
        guard++;
      end
      checkOutput($sformatf("an%0d", d), an, sel);
      checkOutput($sformatf("seg%0d_v%0d", d, v), seg, expSeg(v, d));
    end
  endtask

  function automatic int anIndex(input logic [DIGITS-1:0] a);
    for (int i = 0; i < DIGITS; i++) if (a[i]) return i;
    return 0;
  endfunction

  initial begin
    int bc;
    int cur;
    int v;
    int okCnt;
    int samples;
    int busyCnt;
    int d;
    logic [DIGITS-1:0] expAn;

    reset = 1'b1;
    value = '0;
    #12;
    checkOutput("rstSeg", seg, 7'h00);
    checkOutput("rstAn", an, 0);
    checkOutput("rstBusy", busy, 0);
    @(posedge sysclk);
    #1;
    reset = 1'b0;

    // Scan order and dwell with value 0
    for (int k = 0; k < 12; k++) begin
      step();
      expAn = '0;
      expAn[(k / REFRESH_DIV) % DIGITS] = 1'b1;
      checkOutput($sformatf("scanAn%0d", k), an, expAn);
      checkOutput($sformatf("scanSeg%0d", k), seg, ((k / REFRESH_DIV) % DIGITS == 0) ? 7'h3F : 7'h00);
    end
    repeat (30) step();
    checkOutput("idleAfterFirst", busy, 0);

    // 0 -> 255, then 107 and 7
    applyStimulus(255);
    waitConversion(bc);
    checkOutput("busyLen255", bc, WIDTH + 2);
    checkDisplay(255);
    applyStimulus(107);
    waitConversion(bc);
    checkDisplay(107);
    applyStimulus(7);
    waitConversion(bc);
    checkDisplay(7);

    // 12 -> 200 while the 12 conversion is still shifting
    applyStimulus(12);
    repeat (3) step();
    checkOutput("midShiftBusy", busy, 1);
    applyStimulus(200);
    okCnt = 0;
    samples = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      d = anIndex(an);
      samples++;
      if (seg == expSeg(7, d) || seg == expSeg(12, d) || seg == expSeg(200, d)) okCnt++;
    end
    checkOutput("tornFree", okCnt, samples);
    checkOutput("idleAfter200", busy, 0);
    checkDisplay(200);

    // Reset during SHIFT of 99
    applyStimulus(99);
    repeat (4) step();
    reset = 1'b1;
    #1;
    checkOutput("midRstSeg", seg, 7'h00);
    checkOutput("midRstAn", an, 0);
    checkOutput("midRstBusy", busy, 0);
    step();
    step();
    reset = 1'b0;
    waitConversion(bc);
    checkOutput("busyLen99", bc, WIDTH + 2);
    checkDisplay(99);

    // Stable 255: no spurious restarts
    applyStimulus(255);
    waitConversion(bc);
    checkOutput("busyLenStable", bc, WIDTH + 2);
    busyCnt = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (busy) busyCnt++;
    end
    checkOutput("noRestart", busyCnt, 0);
    checkDisplay(255);
    cur = 255;

    // Random values
    for (int n = 0; n < 15; n++) begin
      v = $urandom_range(0, 255);
      if (v == cur) v = (v + 1) % 256;
      applyStimulus(v);
      waitConversion(bc);
      checkOutput($sformatf("busyLenR%0d", v), bc, WIDTH + 2);
      checkDisplay(v);
      cur = v;
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
